// File: rtl/kbd_common_pkg.sv
// Shared types for the keyboard event path: event layout, bus register map, register bit positions.
package kbd_common;

  localparam int KBD_VK_W = 8;

  typedef struct packed {
    logic                is_break;
    logic [KBD_VK_W-1:0] vk;
  } kbd_event_t;

  typedef enum logic [3:0] {
    REG_DATA    = 4'd0,
    REG_CONTROL = 4'd1,
    REG_STATUS  = 4'd2
  } kbd_reg_t;

  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_FLUSH    = 1;
  localparam int CTRL_OVF      = 2;
  localparam int CTRL_WM_LSB   = 8;

  localparam int DATA_VALID    = 16;

  localparam int STAT_CNT_LSB  = 0;
  localparam int STAT_EMPTY    = 16;
  localparam int STAT_FULL     = 17;
  localparam int STAT_OVF      = 18;
  localparam int STAT_DROP_LSB = 24;

endpackage

// File: rtl/kbd_key_state.sv
// Per-key held bitmap used to suppress typematic repeats (only built with KBD_REPEAT_FILTER_EN).
module kbd_key_state #(
  parameter int VK_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                upd_i,
  input  logic [VK_WIDTH-1:0] vk_i,
  input  logic                is_break_i,
  output logic                held_o
);

  logic [(2**VK_WIDTH)-1:0] held_q;

  assign held_o = held_q[vk_i];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) held_q <= '0;
    else if (upd_i)       held_q[vk_i] <= !is_break_i;
  end

endmodule

// File: rtl/kbd_event_queue.sv
// Bus-facing keyboard event queue with flush, sticky overflow, drop counter and watermark interrupt.
// Define KBD_REPEAT_FILTER_EN to drop make events for keys already held.
module kbd_event_queue
  import kbd_common::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int VK_WIDTH   = 8,
  parameter int DROP_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                interrupt_o,
  input  logic [VK_WIDTH-1:0] vk_i,
  input  logic                is_break_i,
  input  logic                valid_i,
  input  logic                chip_select_i,
  input  logic [3:0]          addr_i,
  input  logic                read_enable_i,
  output logic [31:0]         read_data_o,
  input  logic [31:0]         write_data_i,
  input  logic [3:0]          write_mask_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int EW    = VK_WIDTH + 1;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

  logic [EW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_WIDTH-1:0] drops_q, drops_d;
  logic                  irq_en_q, irq_en_d;
  logic [7:0]            wm_q, wm_d;
  logic                  irq_q, irq_d;
  logic [31:0]           rdata_q, rdata_d;

  logic wr, rd, wr_ctrl, wr_stat, flush, pop, push, ovf_evt, evt;
  logic empty, full;
  logic [7:0]  wm_eff;
  logic [15:0] data_lo;
  logic [31:0] rd_word;
  logic unused_ok;

  assign unused_ok = ^{write_data_i[31:16], write_data_i[7:3], write_mask_i[3:2]};

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign wr      = chip_select_i && !read_enable_i && (write_mask_i != 4'b0);
  assign rd      = chip_select_i && read_enable_i;
  assign wr_ctrl = wr && (addr_i == REG_CONTROL);
  assign wr_stat = wr && (addr_i == REG_STATUS);
  assign flush   = wr_ctrl && write_mask_i[0] && write_data_i[CTRL_FLUSH];
  assign pop     = rd && (addr_i == REG_DATA) && !empty;

`ifdef KBD_REPEAT_FILTER_EN
  logic held;

  kbd_key_state #(.VK_WIDTH(VK_WIDTH)) u_key_state (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (flush),
    .upd_i      (valid_i && !flush),
    .vk_i       (vk_i),
    .is_break_i (is_break_i),
    .held_o     (held)
  );

  // A repeat make never reaches the queue, so it cannot count as a drop.
  assign evt = valid_i && !rst_i && !(held && !is_break_i);
`else
  assign evt = valid_i && !rst_i;
`endif

  // Popping a full queue frees the slot the simultaneous push lands in.
  assign push    = evt && !flush && (!full || pop);
  assign ovf_evt = evt && !flush && full && !pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + DEPTH_LOG2'(1);
      if (push) tail_d = tail_q + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    irq_en_d = irq_en_q;
    wm_d     = wm_q;
    ovf_d    = ovf_q;
    drops_d  = drops_q;
    if (wr_ctrl && write_mask_i[0]) begin
      irq_en_d = write_data_i[CTRL_IRQ_EN];
      if (write_data_i[CTRL_OVF]) ovf_d = 1'b0;
    end
    if (wr_ctrl && write_mask_i[1]) wm_d = write_data_i[CTRL_WM_LSB +: 8];
    if (ovf_evt) ovf_d = 1'b1;
    if (wr_stat)                           drops_d = '0;
    else if (ovf_evt && drops_q != DROP_MAX) drops_d = drops_q + DROP_WIDTH'(1);
  end

  assign wm_eff = (wm_q == 8'd0) ? 8'd1 : wm_q;
  assign irq_d  = irq_en_q && (9'(count_q) >= {1'b0, wm_eff});

  always_comb begin
    data_lo = '0;
    if (!empty) data_lo[EW-1:0] = mem[head_q];
    rd_word = '0;
    case (addr_i)
      REG_DATA: begin
        rd_word[15:0]      = data_lo;
        rd_word[DATA_VALID] = !empty;
      end
      REG_CONTROL: begin
        rd_word[CTRL_IRQ_EN]        = irq_en_q;
        rd_word[CTRL_OVF]           = ovf_q;
        rd_word[CTRL_WM_LSB +: 8]   = wm_q;
      end
      REG_STATUS: begin
        rd_word[STAT_CNT_LSB +: 9]  = 9'(count_q);
        rd_word[STAT_EMPTY]         = empty;
        rd_word[STAT_FULL]          = full;
        rd_word[STAT_OVF]           = ovf_q;
        rd_word[STAT_DROP_LSB +: 8] = 8'(drops_q);
      end
      default: rd_word = '0;
    endcase
    rdata_d = rd ? rd_word : rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[tail_q] <= {is_break_i, vk_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drops_q  <= '0;
      irq_en_q <= 1'b1;
      wm_q     <= 8'd1;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drops_q  <= drops_d;
      irq_en_q <= irq_en_d;
      wm_q     <= wm_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign interrupt_o = irq_q;
  assign read_data_o = rdata_q;

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed bench for kbd_event_queue built with a 4-entry queue.
module tb_kbd_event_queue;
  import kbd_common::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        interrupt_o;
  logic [7:0]  vk_i;
  logic        is_break_i;
  logic        valid_i;
  logic        chip_select_i;
  logic [3:0]  addr_i;
  logic        read_enable_i;
  logic [31:0] read_data_o;
  logic [31:0] write_data_i;
  logic [3:0]  write_mask_i;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  kbd_event_queue #(.DEPTH_LOG2(2), .VK_WIDTH(8), .DROP_WIDTH(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .interrupt_o   (interrupt_o),
    .vk_i          (vk_i),
    .is_break_i    (is_break_i),
    .valid_i       (valid_i),
    .chip_select_i (chip_select_i),
    .addr_i        (addr_i),
    .read_enable_i (read_enable_i),
    .read_data_o   (read_data_o),
    .write_data_i  (write_data_i),
    .write_mask_i  (write_mask_i)
  );

  // Every helper starts and ends on a falling edge, so ops run back to back.
  task automatic idle();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] vk, input logic brk);
    kbd_event_t ev;
    ev.vk = vk; ev.is_break = brk;
    valid_i = 1'b1; vk_i = ev.vk; is_break_i = ev.is_break;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    chip_select_i = 1'b1; read_enable_i = 1'b1; addr_i = a;
    @(negedge clk);
    chip_select_i = 1'b0; read_enable_i = 1'b0;
    d = read_data_o;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    chip_select_i = 1'b1; read_enable_i = 1'b0; addr_i = a; write_data_i = d; write_mask_i = m;
    @(negedge clk);
    chip_select_i = 1'b0; write_mask_i = 4'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_i = 1'b1; valid_i = 1'b1; vk_i = 8'h55;
    repeat (2) @(negedge clk);
    valid_i = 1'b0; rst_i = 1'b0;
    vec_cnt++; if (read_data_o !== 32'h0) begin err_cnt++; $display("FAIL reset_rdata got %h want %h", read_data_o, 32'h0); end
    vec_cnt++; if (interrupt_o !== 1'b0) begin err_cnt++; $display("FAIL reset_irq got %b want 0", interrupt_o); end
    bus_read(REG_STATUS, d);
    vec_cnt++; if (d !== 32'h0001_0000) begin err_cnt++; $display("FAIL reset_status got %h want %h", d, 32'h0001_0000); end
    bus_read(REG_CONTROL, d);
    vec_cnt++; if (d !== 32'h0000_0101) begin err_cnt++; $display("FAIL reset_control got %h want %h", d, 32'h0000_0101); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    push(8'h1C, 1'b0);
    push(8'h1C, 1'b1);
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0001_001C) begin err_cnt++; $display("FAIL basic_rd0 got %h want %h", d, 32'h0001_001C); end
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0001_011C) begin err_cnt++; $display("FAIL basic_rd1 got %h want %h", d, 32'h0001_011C); end
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL basic_rd_empty got %h want %h", d, 32'h0); end
    idle();
    vec_cnt++; if (read_data_o !== 32'h0) begin err_cnt++; $display("FAIL basic_hold got %h want 0", read_data_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i), 1'b0);
    bus_read(REG_STATUS, d);
    vec_cnt++; if (d !== 32'h0206_0004) begin err_cnt++; $display("FAIL ovf_status got %h want %h", d, 32'h0206_0004); end
    for (int i = 0; i < 4; i++) begin
      bus_read(REG_DATA, d);
      vec_cnt++; if (d !== 32'h0001_0011 + 32'(i)) begin err_cnt++; $display("FAIL ovf_order%0d got %h want %h", i, d, 32'h0001_0011 + 32'(i)); end
    end
    bus_write(REG_CONTROL, 32'h0000_0005, 4'b0001);
    bus_write(REG_STATUS, 32'h0, 4'b0001);
    bus_read(REG_STATUS, d);
    vec_cnt++; if (d !== 32'h0001_0000) begin err_cnt++; $display("FAIL ovf_cleared got %h want %h", d, 32'h0001_0000); end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i), 1'b0);
    valid_i = 1'b1; vk_i = 8'h25; is_break_i = 1'b0;
    chip_select_i = 1'b1; read_enable_i = 1'b1; addr_i = REG_DATA;
    @(negedge clk);
    valid_i = 1'b0; chip_select_i = 1'b0; read_enable_i = 1'b0;
    vec_cnt++; if (read_data_o !== 32'h0001_0021) begin err_cnt++; $display("FAIL fpp_head got %h want %h", read_data_o, 32'h0001_0021); end
    bus_read(REG_STATUS, d);
    vec_cnt++; if (d !== 32'h0002_0004) begin err_cnt++; $display("FAIL fpp_status got %h want %h", d, 32'h0002_0004); end
    for (int i = 0; i < 4; i++) begin
      bus_read(REG_DATA, d);
      vec_cnt++; if (d !== 32'h0001_0022 + 32'(i)) begin err_cnt++; $display("FAIL fpp_drain%0d got %h want %h", i, d, 32'h0001_0022 + 32'(i)); end
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(REG_CONTROL, 32'h0000_0301, 4'b0011);
    push(8'h31, 1'b0);
    push(8'h32, 1'b0);
    idle();
    vec_cnt++; if (interrupt_o !== 1'b0) begin err_cnt++; $display("FAIL irq_below got %b want 0", interrupt_o); end
    push(8'h33, 1'b0);
    vec_cnt++; if (interrupt_o !== 1'b0) begin err_cnt++; $display("FAIL irq_early got %b want 0", interrupt_o); end
    idle();
    vec_cnt++; if (interrupt_o !== 1'b1) begin err_cnt++; $display("FAIL irq_at_wm got %b want 1", interrupt_o); end
    bus_read(REG_DATA, d);
    idle();
    vec_cnt++; if (interrupt_o !== 1'b0) begin err_cnt++; $display("FAIL irq_after_pop got %b want 0", interrupt_o); end
    bus_write(REG_CONTROL, 32'h0000_0000, 4'b0001);
    push(8'h34, 1'b0);
    idle(); idle();
    vec_cnt++; if (interrupt_o !== 1'b0) begin err_cnt++; $display("FAIL irq_masked got %b want 0", interrupt_o); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    bus_write(REG_CONTROL, 32'h0000_0103, 4'b0011);
    push(8'h41, 1'b0); push(8'h42, 1'b1); push(8'h43, 1'b0);
    idle();
    vec_cnt++; if (interrupt_o !== 1'b1) begin err_cnt++; $display("FAIL flush_pre_irq got %b want 1", interrupt_o); end
    valid_i = 1'b1; vk_i = 8'h44; is_break_i = 1'b0;
    chip_select_i = 1'b1; read_enable_i = 1'b0; addr_i = REG_CONTROL;
    write_data_i = 32'h0000_0103; write_mask_i = 4'b0011;
    @(negedge clk);
    valid_i = 1'b0; chip_select_i = 1'b0; write_mask_i = 4'b0;
    bus_read(REG_STATUS, d);
    vec_cnt++; if (d !== 32'h0001_0000) begin err_cnt++; $display("FAIL flush_status got %h want %h", d, 32'h0001_0000); end
    vec_cnt++; if (interrupt_o !== 1'b0) begin err_cnt++; $display("FAIL flush_irq got %b want 0", interrupt_o); end
    bus_read(REG_CONTROL, d);
    vec_cnt++; if (d !== 32'h0000_0101) begin err_cnt++; $display("FAIL flush_ctrl got %h want %h", d, 32'h0000_0101); end
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0) begin err_cnt++; $display("FAIL flush_data got %h want 0", d); end
  endtask

  task automatic test_repeat();
    logic [31:0] d;
    push(8'h1C, 1'b0); push(8'h1C, 1'b0); push(8'h1C, 1'b0);
    push(8'h1C, 1'b1); push(8'h1C, 1'b0);
    bus_read(REG_STATUS, d);
`ifdef KBD_REPEAT_FILTER_EN
    vec_cnt++; if (d !== 32'h0000_0003) begin err_cnt++; $display("FAIL rpt_status got %h want %h", d, 32'h0000_0003); end
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0001_001C) begin err_cnt++; $display("FAIL rpt_rd0 got %h want %h", d, 32'h0001_001C); end
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0001_011C) begin err_cnt++; $display("FAIL rpt_rd1 got %h want %h", d, 32'h0001_011C); end
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0001_001C) begin err_cnt++; $display("FAIL rpt_rd2 got %h want %h", d, 32'h0001_001C); end
`else
    vec_cnt++; if (d !== 32'h0106_0004) begin err_cnt++; $display("FAIL rpt_status got %h want %h", d, 32'h0106_0004); end
    for (int i = 0; i < 3; i++) begin
      bus_read(REG_DATA, d);
      vec_cnt++; if (d !== 32'h0001_001C) begin err_cnt++; $display("FAIL rpt_make%0d got %h want %h", i, d, 32'h0001_001C); end
    end
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0001_011C) begin err_cnt++; $display("FAIL rpt_break got %h want %h", d, 32'h0001_011C); end
`endif
    bus_write(REG_CONTROL, 32'h0000_0107, 4'b0011);
    bus_write(REG_STATUS, 32'h0, 4'b0001);
  endtask

  task automatic test_drop_saturate();
    logic [31:0] d;
    for (int i = 0; i < 4 + 300; i++) push(8'(i), 1'b1);
    bus_read(REG_STATUS, d);
    vec_cnt++; if (d !== 32'hFF06_0004) begin err_cnt++; $display("FAIL sat_status got %h want %h", d, 32'hFF06_0004); end
    bus_read(REG_DATA, d);
    vec_cnt++; if (d !== 32'h0001_0100) begin err_cnt++; $display("FAIL sat_head got %h want %h", d, 32'h0001_0100); end
    bus_write(REG_STATUS, 32'h0, 4'b0010);
    bus_write(REG_CONTROL, 32'h0000_0107, 4'b0011);
    bus_read(REG_STATUS, d);
    vec_cnt++; if (d !== 32'h0001_0000) begin err_cnt++; $display("FAIL sat_clear got %h want %h", d, 32'h0001_0000); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    bus_write(REG_CONTROL, 32'h0000_0200, 4'b0011);
    push(8'h51, 1'b0); push(8'h52, 1'b0);
    rst_i = 1'b1; valid_i = 1'b1; vk_i = 8'h53; is_break_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0; valid_i = 1'b0;
    vec_cnt++; if (interrupt_o !== 1'b0) begin err_cnt++; $display("FAIL mrst_irq got %b want 0", interrupt_o); end
    bus_read(REG_STATUS, d);
    vec_cnt++; if (d !== 32'h0001_0000) begin err_cnt++; $display("FAIL mrst_status got %h want %h", d, 32'h0001_0000); end
    bus_read(REG_CONTROL, d);
    vec_cnt++; if (d !== 32'h0000_0101) begin err_cnt++; $display("FAIL mrst_ctrl got %h want %h", d, 32'h0000_0101); end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; vk_i = '0; is_break_i = 1'b0;
    chip_select_i = 1'b0; read_enable_i = 1'b0; addr_i = '0;
    write_data_i = '0; write_mask_i = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop_push();
    test_irq();
    test_flush();
    test_repeat();
    test_drop_saturate();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
